// File: rtl/bram_ctrl_pkg.sv
// bram_ctrl_pkg: shared FSM encoding and BRAM port constants
package bram_ctrl_pkg;
  typedef enum logic [3:0] {IDLE, RDA0, RDA1, RDA2, RDB0, RDB1, RDB2, WR, DONE} state_t;
  localparam logic [3:0] WE_ALL = 4'hF;
  localparam logic [3:0] WE_NONE = 4'h0;
  localparam int RD_LATENCY = 2;
  localparam int BYTE_SHIFT = 2;
endpackage

// File: rtl/vec_add_bram_master.sv
// vec_add_bram_master: reads A and B from a single-port BRAM and writes back C = A + B
module vec_add_bram_master
  import bram_ctrl_pkg::*;
#(
  parameter int BRAM_ADDR_WIDTH = 15,
  parameter int VEC_LEN = 1024
) (
  input  logic                       BRAM_CLK,
  input  logic                       BRAM_RST,
  input  logic                       start,
  output logic [BRAM_ADDR_WIDTH-1:0] BRAM_ADDR,
  output logic [31:0]                BRAM_WRDATA,
  output logic                       BRAM_EN,
  output logic [3:0]                 BRAM_WE,
  input  logic [31:0]                BRAM_RDDATA,
  output logic                       busy,
  output logic                       done
);
  localparam int WW = BRAM_ADDR_WIDTH - 2;
  localparam logic [WW-1:0] LAST = WW'(VEC_LEN - 1);
  localparam logic [WW-1:0] B_BASE = WW'(VEC_LEN);
  localparam logic [WW-1:0] C_BASE = WW'(2 * VEC_LEN);
  if (3 * VEC_LEN > 2 ** WW) begin : g_len_chk
    $fatal(1, "three vectors of VEC_LEN words do not fit in the BRAM address space");
  end
  state_t state, state_nxt;
  logic [WW-1:0] i, i_nxt, word_nxt;
  logic [31:0] a_reg, b_reg, a_nxt, b_nxt;
  logic rd_a, rd_b, wr;
  // next state, element index and operand capture at the end of each read's hold window
  always_comb begin
    state_nxt = state;
    i_nxt = i;
    a_nxt = a_reg;
    b_nxt = b_reg;
    case (state)
      IDLE, DONE: if (start) begin
        state_nxt = RDA0;
        i_nxt = '0;
      end
      RDA0: state_nxt = RDA1;
      RDA1: state_nxt = RDA2;
      RDA2: begin
        state_nxt = RDB0;
        a_nxt = BRAM_RDDATA;
      end
      RDB0: state_nxt = RDB1;
      RDB1: state_nxt = RDB2;
      RDB2: begin
        state_nxt = WR;
        b_nxt = BRAM_RDDATA;
      end
      WR: if (i == LAST) state_nxt = DONE;
          else begin
            state_nxt = RDA0;
            i_nxt = i + 1'b1;
          end
      default: state_nxt = IDLE;
    endcase
  end
  // outputs are registered, so decode them from the state being entered
  always_comb begin
    rd_a = state_nxt inside {RDA0, RDA1, RDA2};
    rd_b = state_nxt inside {RDB0, RDB1, RDB2};
    wr = state_nxt == WR;
    word_nxt = rd_a ? i_nxt : rd_b ? B_BASE + i_nxt : wr ? C_BASE + i_nxt : '0;
  end
  // FSM state register
  always_ff @(posedge BRAM_CLK) begin
    if (BRAM_RST) state <= IDLE;
    else state <= state_nxt;
  end
  // datapath and registered BRAM port
  always_ff @(posedge BRAM_CLK) begin
    if (BRAM_RST) begin
      i <= '0;
      a_reg <= '0;
      b_reg <= '0;
      BRAM_ADDR <= '0;
      BRAM_WRDATA <= '0;
      BRAM_EN <= 1'b0;
      BRAM_WE <= WE_NONE;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      i <= i_nxt;
      a_reg <= a_nxt;
      b_reg <= b_nxt;
      BRAM_ADDR <= BRAM_ADDR_WIDTH'(word_nxt) << BYTE_SHIFT;
      BRAM_WRDATA <= wr ? a_nxt + b_nxt : '0;
      BRAM_EN <= rd_a | rd_b | wr;
      BRAM_WE <= wr ? WE_ALL : WE_NONE;
      busy <= rd_a | rd_b | wr;
      done <= state_nxt == DONE;
    end
  end
endmodule

// File: tb/tb_vec_add_bram_master.sv
// tb_vec_add_bram_master: randomized self-checking bench with a 2-cycle-latency BRAM model
module tb_vec_add_bram_master;
  localparam int AW = 15;
  localparam int N = 4;
  localparam int OW = AW + 39;
  localparam logic [31:0] SENT = 32'hDEAD_BEEF;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic load = 1'b0;
  logic [AW-1:0] addr;
  logic [31:0] wd, rd, s1;
  logic en, busy, done;
  logic [3:0] we;
  logic [31:0] mem [0:15];
  logic [31:0] a_v [N];
  logic [31:0] b_v [N];
  int n_vec = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  vec_add_bram_master #(.BRAM_ADDR_WIDTH(AW), .VEC_LEN(N)) my_bram (
    .BRAM_CLK(clk), .BRAM_RST(rst), .start(start), .BRAM_ADDR(addr), .BRAM_WRDATA(wd),
    .BRAM_EN(en), .BRAM_WE(we), .BRAM_RDDATA(rd), .busy(busy), .done(done)
  );
  // BRAM model: data for an address appears two edges after it is presented
  always @(posedge clk) begin
    if (load) begin
      for (int j = 0; j < N; j++) begin
        mem[j] <= a_v[j];
        mem[N+j] <= b_v[j];
        mem[2*N+j] <= SENT;
      end
    end else if (en && we == 4'hF) mem[addr[5:2]] <= wd;
    if (en) s1 <= mem[addr[5:2]];
    rd <= s1;
  end

  task automatic randomize_vecs();
    for (int j = 0; j < N; j++) begin
      a_v[j] = $urandom;
      b_v[j] = $urandom;
    end
  endtask

  // one full run: optional reload, start pulse, per-cycle port trace vs model, then memory contents
  task automatic run_scenario(input string name, input bit reload, input int mid_start, input int rst_at);
    logic [OW-1:0] got, exp;
    logic [31:0] exp_c;
    int e, p, n_w;
    n_w = rst_at > 0 ? rst_at / 7 : N;
    if (reload) begin
      @(negedge clk);
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
    end
    start = 1'b1;
    for (int k = 1; k <= 7 * N + 1; k++) begin
      @(negedge clk);
      start = k == mid_start;
      e = (k - 1) / 7;
      p = (k - 1) % 7;
      if (k > 7 * N) exp = {AW'(0), 32'd0, 1'b0, 4'h0, 1'b0, 1'b1};
      else if (p < 3) exp = {AW'(e * 4), 32'd0, 1'b1, 4'h0, 1'b1, 1'b0};
      else if (p < 6) exp = {AW'((N + e) * 4), 32'd0, 1'b1, 4'h0, 1'b1, 1'b0};
      else exp = {AW'((2 * N + e) * 4), 32'(a_v[e] + b_v[e]), 1'b1, 4'hF, 1'b1, 1'b0};
      got = {addr, wd, en, we, busy, done};
      n_vec++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL %s port trace cycle %0d: got %h expected %h", name, k, got, exp);
      end
      if (k == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        got = {addr, wd, en, we, busy, done};
        n_vec++;
        if (got !== '0) begin
          n_bad++;
          $display("FAIL %s after reset: got %h expected 0", name, got);
        end
        break;
      end
    end
    for (int j = 0; j < N; j++) begin
      exp_c = j < n_w ? a_v[j] + b_v[j] : SENT;
      n_vec += 3;
      if (mem[j] !== a_v[j]) begin
        n_bad++;
        $display("FAIL %s A[%0d]: got %h expected %h", name, j, mem[j], a_v[j]);
      end
      if (mem[N+j] !== b_v[j]) begin
        n_bad++;
        $display("FAIL %s B[%0d]: got %h expected %h", name, j, mem[N+j], b_v[j]);
      end
      if (mem[2*N+j] !== exp_c) begin
        n_bad++;
        $display("FAIL %s C[%0d]: got %h expected %h", name, j, mem[2*N+j], exp_c);
      end
    end
  endtask

  task automatic test_reset();
    logic [OW-1:0] got;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    got = {addr, wd, en, we, busy, done};
    n_vec++;
    if (got !== '0) begin
      n_bad++;
      $display("FAIL reset outputs: got %h expected 0", got);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    for (int j = 0; j < N; j++) begin
      a_v[j] = 32'(j + 1);
      b_v[j] = 32'(10 * (j + 1));
    end
    run_scenario("basic", 1'b1, 0, 0);
  endtask

  task automatic test_wrap();
    randomize_vecs();
    a_v[0] = 32'hFFFF_FFFF;
    b_v[0] = 32'h0000_0002;
    run_scenario("wrap", 1'b1, 0, 0);
    n_vec++;
    if (mem[2*N] !== 32'h0000_0001) begin
      n_bad++;
      $display("FAIL wrap C[0]: got %h expected 00000001", mem[2*N]);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      randomize_vecs();
      run_scenario("random", 1'b1, 0, 0);
    end
  endtask

  task automatic test_mid_start();
    randomize_vecs();
    run_scenario("mid_start", 1'b1, 10, 0);
  endtask

  task automatic test_reset_mid();
    randomize_vecs();
    run_scenario("reset_mid", 1'b1, 0, 19);
    run_scenario("restart", 1'b0, 0, 0);
  endtask

  task automatic test_restart_done();
    randomize_vecs();
    run_scenario("restart_done", 1'b1, 0, 0);
  endtask

  task automatic test_reset_start();
    logic [OW-1:0] got;
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      got = {addr, wd, en, we, busy, done};
      n_vec++;
      if (got !== '0) begin
        n_bad++;
        $display("FAIL reset_start cycle %0d: got %h expected 0", k, got);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_random();
    test_mid_start();
    test_reset_mid();
    test_restart_done();
    test_reset_start();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
